// File: rtl/hamming_serial_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hamming_serial_tx_if                                                 |
// | Word handshake and serial-line bundle for the Hamming transmitter.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface hamming_serial_tx_if #(
  parameter int WIDTH = 128
);
  localparam int FRAME_BITS = (WIDTH / 4) * 7;
  localparam int PW         = $clog2(FRAME_BITS);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             inject_en;
  logic [PW-1:0]    inject_pos;
  logic             tx_en;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             frame_done;
  logic             busy;

  modport master (
    output in_valid, in_data, inject_en, inject_pos, tx_en,
    input  in_ready, serial_out, serial_valid, frame_start, frame_done, busy
  );

  modport slave (
    input  in_valid, in_data, inject_en, inject_pos, tx_en,
    output in_ready, serial_out, serial_valid, frame_start, frame_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/hamming_serial_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hamming_serial_tx                                                    |
// | Splits a word into nibbles, Hamming(7,4)-encodes each, and streams   |
// | the frame LSB first with an optional single-bit fault injection.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hamming_serial_tx #(
  parameter int WIDTH = 128
) (
  input  wire                 clk,
  input  wire                 rst,
  hamming_serial_tx_if.slave  bus
);
  localparam int NIBBLES    = WIDTH / 4;
  localparam int FRAME_BITS = NIBBLES * 7;
  localparam int PW         = $clog2(FRAME_BITS);
  localparam logic [PW-1:0] C_LAST_BIT = PW'(FRAME_BITS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic             r_inj_en;
  logic [PW-1:0]    r_inj_pos;
  logic [PW-1:0]    r_bit;
  logic [2:0]       r_j;
  logic             r_serial_out;
  logic             r_serial_valid;
  logic             r_frame_start;
  logic             r_frame_done;
  logic             r_busy;
  logic             r_in_ready;

  logic [3:0]       w_d;
  logic             w_code_bit;
  logic             w_flip;
  logic             w_last;

  // The current nibble always sits in the low bits of the shifted capture.
  always_comb begin
    w_d        = r_shift[3:0];
    w_code_bit = 1'b0;
    case (r_j)
      3'd0:    w_code_bit = w_d[0];
      3'd1:    w_code_bit = w_d[1];
      3'd2:    w_code_bit = w_d[2];
      3'd3:    w_code_bit = w_d[3];
      3'd4:    w_code_bit = w_d[0] ^ w_d[2] ^ w_d[3];
      3'd5:    w_code_bit = w_d[0] ^ w_d[1] ^ w_d[3];
      default: w_code_bit = w_d[0] ^ w_d[1] ^ w_d[2];
    endcase
  end

  // Out-of-range inject positions never match since r_bit stays below FRAME_BITS.
  assign w_flip = r_inj_en && (r_bit == r_inj_pos);
  assign w_last = (r_bit == C_LAST_BIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_shift        <= '0;
      r_inj_en       <= 1'b0;
      r_inj_pos      <= '0;
      r_bit          <= '0;
      r_j            <= 3'd0;
      r_serial_out   <= 1'b0;
      r_serial_valid <= 1'b0;
      r_frame_start  <= 1'b0;
      r_frame_done   <= 1'b0;
      r_busy         <= 1'b0;
      r_in_ready     <= 1'b1;
    end else begin
      r_serial_valid <= 1'b0;
      r_frame_start  <= 1'b0;
      r_frame_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_shift    <= bus.in_data;
            r_inj_en   <= bus.inject_en;
            r_inj_pos  <= bus.inject_pos;
            r_bit      <= '0;
            r_j        <= 3'd0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= S_SEND;
          end
        end
        default: begin
          if (bus.tx_en) begin
            r_serial_out   <= w_code_bit ^ w_flip;
            r_serial_valid <= 1'b1;
            r_frame_start  <= (r_bit == '0);
            r_frame_done   <= w_last;
            if (w_last) begin
              r_busy     <= 1'b0;
              r_in_ready <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_bit <= r_bit + PW'(1);
              if (r_j == 3'd6) begin
                r_j     <= 3'd0;
                r_shift <= r_shift >> 4;
              end else begin
                r_j <= r_j + 3'd1;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.serial_out   = r_serial_out;
  assign bus.serial_valid = r_serial_valid;
  assign bus.frame_start  = r_frame_start;
  assign bus.frame_done   = r_frame_done;
  assign bus.busy         = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_hamming_serial_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hamming_serial_tx                                                 |
// | Scoreboard bench: directed frames with hand-computed serial images.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_hamming_serial_tx;
  localparam int WIDTH      = 128;
  localparam int FRAME_BITS = (WIDTH / 4) * 7;
  localparam int PW         = $clog2(FRAME_BITS);

  // Frame images, bit b of the constant is serial bit b.
  localparam logic [FRAME_BITS-1:0] F_0B   = 224'h2B;
  localparam logic [FRAME_BITS-1:0] F_F0   = 224'h3F80;
  localparam logic [FRAME_BITS-1:0] F_BIT3 = 224'h8;
  localparam logic [FRAME_BITS-1:0] F_ZERO = 224'h0;
  localparam logic [FRAME_BITS-1:0] F_05   = 224'h25;
  localparam logic [FRAME_BITS-1:0] F_05_I = 224'h25 | (224'h1 << 223);

  typedef struct packed {
    logic b;
    logic s;
    logic d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   bits_seen = 0;
  logic last_out = 1'b0;
  logic tx_at_edge = 1'b0;
  logic tx_toggle = 1'b0;
  logic [3:0] pat = 4'b1001;
  exp_t sb[$];

  hamming_serial_tx_if #(.WIDTH(WIDTH)) bus ();

  hamming_serial_tx #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tx_at_edge <= bus.tx_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [FRAME_BITS-1:0] f);
    for (int i = 0; i < FRAME_BITS; i++)
      sb.push_back('{b: f[i], s: (i == 0), d: (i == FRAME_BITS - 1)});
  endtask

  task automatic issue(input logic [WIDTH-1:0] data, input logic inj, input logic [PW-1:0] pos,
                       input logic [FRAME_BITS-1:0] exp, input bit hold);
    int n;
    bus.in_data    = data;
    bus.inject_en  = inj;
    bus.inject_pos = pos;
    bus.in_valid   = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("handshake_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    push_frame(exp);
    #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || sb.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout", n < 3000, 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_serial_out", bus.serial_out, 0);
    check("rst_serial_valid", bus.serial_valid, 0);
    check("rst_frame_start", bus.frame_start, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);
  endtask

  // Bit-rate tick: constant 1, or the 1,0,0,1 pattern when toggling.
  initial begin
    int idx = 0;
    bus.tx_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tx_toggle) begin
        bus.tx_en = pat[idx];
        idx = (idx + 1) % 4;
      end else begin
        bus.tx_en = 1'b1;
      end
    end
  end

  // Monitor: pops one expected bit per serial_valid cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("valid_in_reset", bus.serial_valid, 0);
        last_out = 1'b0;
      end else if (bus.serial_valid) begin
        check("valid_needs_tx_en", tx_at_edge, 1);
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_bit: got serial_valid=1 expected no bit at %0t", $time);
        end else begin
          e = sb.pop_front();
          bits_seen++;
          check("serial_out", bus.serial_out, e.b);
          check("frame_start", bus.frame_start, e.s);
          check("frame_done", bus.frame_done, e.d);
          check("busy", bus.busy, !e.d);
          check("in_ready", bus.in_ready, e.d);
        end
        last_out = bus.serial_out;
      end else begin
        check("hold_serial_out", bus.serial_out, last_out);
        check("idle_frame_start", bus.frame_start, 0);
        check("idle_frame_done", bus.frame_done, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int n;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.inject_en  = 1'b0;
    bus.inject_pos = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b1;

    @(negedge clk);
    issue(128'h0B, 1'b0, '0, F_0B, 1'b0);
    wait_idle();
    issue(128'hF0, 1'b0, '0, F_F0, 1'b0);
    wait_idle();
    issue(128'h0, 1'b1, PW'(3), F_BIT3, 1'b0);
    wait_idle();
    issue(128'h0, 1'b1, PW'(224), F_ZERO, 1'b0);
    wait_idle();
    issue(128'h05, 1'b1, PW'(223), F_05_I, 1'b0);
    wait_idle();

    // Gapped tick with a second word held on in_valid throughout the frame.
    tx_toggle = 1'b1;
    issue(128'h0B, 1'b0, '0, F_0B, 1'b1);
    issue(128'h05, 1'b0, '0, F_05, 1'b0);
    wait_idle();
    tx_toggle = 1'b0;
    repeat (2) @(negedge clk);

    // Abort after bit 50, then restart from bit 0.
    start = bits_seen;
    issue(128'h0B, 1'b0, '0, F_0B, 1'b0);
    n = 0;
    while (bits_seen < start + 51 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_bit50", bits_seen - start, 51);
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("no_resume_busy", bus.busy, 0);
    issue(128'h0B, 1'b0, '0, F_0B, 1'b0);
    wait_idle();

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/hamming_serial_tx.md
Name: hamming_serial_tx

Overview:
Transmit-side counterpart of the team's Hamming-protected shift register. Accepts a WIDTH-bit parallel word over a valid/ready handshake and splits it into 4-bit nibbles. Encodes each nibble into a 7-bit Hamming codeword and streams the frame out serially, one bit per tx_en tick, to the protected register's serial input. Includes a single-bit fault-injection hook so the receiver's syndrome and correction logic can be exercised.

Parameters:
- WIDTH, 128, payload width in bits; must be a multiple of 4.
- NIBBLES (localparam), WIDTH/4, codewords per frame.
- FRAME_BITS (localparam), NIBBLES*7, serial bits per frame (224 at default).
- PW (localparam), $clog2(FRAME_BITS), bit-index width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block idle and able to accept a word.
- in_data  input  WIDTH  payload word.
- inject_en  input  1  request a single-bit flip in this frame; sampled at handshake.
- inject_pos  input  PW  frame bit index to flip; sampled at handshake.
- tx_en  input  1  bit-rate tick; one bit advances per clk with tx_en=1.
- serial_out  output  1  serial line, registered.
- serial_valid  output  1  serial_out carries a new bit this cycle.
- frame_start  output  1  pulse coincident with frame bit 0.
- frame_done  output  1  pulse coincident with last frame bit.
- busy  output  1  frame in progress.

Behaviour:
- Reset (rst=0, async) forces: state IDLE, serial_out=0, serial_valid=0, frame_start=0, frame_done=0, busy=0, bit counters=0, capture registers=0. in_ready=1 once in IDLE.
- Reset mid-frame aborts the frame. No further bits are sent, frame_done does not pulse, and no resume occurs after release.
- FSM states:
  - IDLE: in_ready=1. in_valid&&in_ready at an edge captures in_data, inject_en and inject_pos, then goes to SEND.
  - SEND: in_ready=0, busy=1. in_valid is ignored and nothing is captured.
- Bit emission in SEND: at each edge with tx_en=1, serial_out is loaded with frame bit b and serial_valid=1 for the following cycle; b then increments.
- Edge with tx_en=0: serial_out holds its value, serial_valid=0, b unchanged.
- Frame ordering, LSB first: b = 7*k + j, where k = nibble 0..NIBBLES-1 and nibble k = in_data[4k+3:4k].
- Within a nibble, j=0..6 sends d0, d1, d2, d3, p1, p2, p3, with:
  - p1 = d0^d2^d3
  - p2 = d0^d1^d3
  - p3 = d0^d1^d2
- Injection: if captured inject_en=1 and b==captured inject_pos, the emitted bit is inverted. inject_pos >= FRAME_BITS means no flip. At most one bit per frame is flipped.
- frame_start=1 exactly in the serial_valid cycle of b=0.
- frame_done=1 exactly in the serial_valid cycle of b=FRAME_BITS-1.
- The edge that emits the last bit returns the FSM to IDLE. busy=0 and in_ready=1 in the cycle that cycle's frame_done is high.
- Latency: handshake at edge N. With tx_en=1 continuously, bit 0 is valid in the cycle after edge N+1, and the last bit is valid after edge N+FRAME_BITS.
- Back-to-back: in_valid held high is accepted again at the edge ending the frame_done cycle, so there is one idle clk between frames.
- Encoding is combinational from the captured word and counters; output is registered only on serial_out and the strobes.

Test Plan:
- Reset values: assert rst=0 mid-sim, check all outputs → serial_out=0, serial_valid=0, frame_start=0, frame_done=0, busy=0, in_ready=1.
- in_data=128'h0B, inject_en=0, tx_en=1 constant → bits 0..6 = 1,1,0,1,0,1,0, bits 7..223 = 0. frame_start with bit 0, frame_done with bit 223, 224 serial_valid cycles.
- in_data=128'hF0, inject_en=0 → bits 0..6 = 0, bits 7..13 = 1,1,1,1,1,1,1, rest 0.
- in_data=0, inject_en=1, inject_pos=3 → only bit 3 = 1. Repeat with inject_pos=224 → all zeros.
- tx_en toggling 1,0,0,1 on in_data=128'h0B → serial_valid only after tx_en=1 edges, serial_out holds during gaps, bit sequence unchanged. Hold in_valid high with a second word → second word not captured before frame_done.
- rst=0 after bit 50 → outputs reset, no frame_done. After release and a new handshake, the frame restarts at bit 0.
